// File: rtl/riscv_pkg.sv
// Constants shared by the RV32 front-end blocks.
package riscv_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0, x0, 0

    typedef logic [31:0] instr_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to a 1-cycle-latency instruction memory,
// presents the returned word with its PC and fault flag, and holds it across stalls.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH     = 32,
    parameter int unsigned             RAM_SIZE_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC       = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  ram_flush,
    input  instr_t                ram_instruction,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output instr_t                if_instruction,
    output logic                  if_fault
);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  fault;
    } resp_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INSTR_BYTES);
    // One extra bit so a RAM as large as the address space still compares correctly.
    localparam logic [ADDR_WIDTH:0]   RAM_LAST =
        (ADDR_WIDTH+1)'((64'd1 << RAM_SIZE_WIDTH) - 64'(INSTR_BYTES));

    function automatic logic fetch_fault(input logic [ADDR_WIDTH-1:0] pc);
        return (pc[1:0] != 2'b00) || ({1'b0, pc} > RAM_LAST);
    endfunction

    logic [ADDR_WIDTH-1:0] fetch_pc;
    resp_t                 resp;
    logic                  hold_active;
    instr_t                hold_instr;

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values; hold_instr is reset as well so if_instruction is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp        <= '0;
            hold_active <= 1'b0;
            hold_instr  <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            resp.valid  <= 1'b0;
            hold_active <= 1'b0;
        end else if (stall) begin
            // The memory has already moved on to fetch_pc, so capture the word now.
            if (!hold_active) begin
                hold_instr  <= ram_instruction;
                hold_active <= 1'b1;
            end
        end else begin
            fetch_pc    <= fetch_pc + PC_STEP;
            resp.valid  <= 1'b1;
            resp.pc     <= fetch_pc;
            resp.fault  <= fetch_fault(fetch_pc);
            hold_active <= 1'b0;
        end
    end

    assign pc_out    = fetch_pc;
    assign ram_flush = redirect;
    assign if_valid  = resp.valid & ~redirect;
    assign if_pc     = resp.pc;
    assign if_fault  = resp.valid & resp.fault & ~redirect;

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        if_instruction = NOP_INSTR;
        if (if_valid && !if_fault) begin
            if (hold_active) if_instruction = hold_instr;
            else             if_instruction = ram_instruction;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch against a 1-cycle registered memory model.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic        ram_flush;
    logic [31:0] ram_instruction = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_fault;

    int vectors     = 0;
    int miscompares = 0;

    instruction_fetch #(
        .ADDR_WIDTH     (32),
        .RAM_SIZE_WIDTH (16),
        .RESET_PC       (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .pc_out          (pc_out),
        .ram_flush       (ram_flush),
        .ram_instruction (ram_instruction),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instruction  (if_instruction),
        .if_fault        (if_fault)
    );

    always #5 clk = ~clk;

    // Memory holds word k = 0x1000_0000 + k at byte address 4k.
    always @(posedge clk) ram_instruction <= 32'h1000_0000 + (pc_out >> 2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(); tick();
        vectors++;
        if (pc_out !== 32'h0) begin miscompares++; $display("FAIL reset_pc_out got %h want %h", pc_out, 32'h0); end
        vectors++;
        if (if_valid !== 1'b0 || if_fault !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags got valid=%b fault=%b want 0/0", if_valid, if_fault);
        end
        vectors++;
        if (if_instruction !== NOP) begin miscompares++; $display("FAIL reset_instr got %h want %h", if_instruction, NOP); end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (if_valid !== 1'b0 || pc_out !== 32'h0) begin
            miscompares++; $display("FAIL release_cycle got valid=%b pc_out=%h want 0/0", if_valid, pc_out);
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (pc_out !== 32'(4*i) || if_valid !== 1'b1 || if_pc !== 32'(4*(i-1)) ||
                if_instruction !== 32'h1000_0000 + 32'(i-1)) begin
                miscompares++;
                $display("FAIL seq_%0d got pc_out=%h valid=%b if_pc=%h instr=%h want %h/1/%h/%h",
                         i, pc_out, if_valid, if_pc, if_instruction, 4*i, 4*(i-1), 32'h1000_0000 + 32'(i-1));
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) stall = 1'b0;
            #1;
            vectors++;
            if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instruction !== 32'h1000_0002 || pc_out !== 32'hC) begin
                miscompares++;
                $display("FAIL stall_%0d got valid=%b if_pc=%h instr=%h pc_out=%h want 1/8/10000002/c",
                         c, if_valid, if_pc, if_instruction, pc_out);
            end
            tick();
        end
        vectors++;
        if (if_pc !== 32'hC || if_instruction !== 32'h1000_0003 || if_valid !== 1'b1) begin
            miscompares++; $display("FAIL stall_after got if_pc=%h instr=%h want c/10000003", if_pc, if_instruction);
        end
        tick();
        vectors++;
        if (if_pc !== 32'h10 || if_instruction !== 32'h1000_0004) begin
            miscompares++; $display("FAIL stall_after2 got if_pc=%h instr=%h want 10/10000004", if_pc, if_instruction);
        end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        vectors++;
        if (if_valid !== 1'b0 || ram_flush !== 1'b1) begin
            miscompares++; $display("FAIL redir_cycle got valid=%b flush=%b want 0/1", if_valid, ram_flush);
        end
        tick();
        redirect = 1'b0;
        #1;
        vectors++;
        if (if_valid !== 1'b0 || ram_flush !== 1'b0 || pc_out !== 32'h100) begin
            miscompares++; $display("FAIL redir_bubble got valid=%b flush=%b pc_out=%h want 0/0/100", if_valid, ram_flush, pc_out);
        end
        tick();
        vectors++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instruction !== 32'h1000_0040) begin
            miscompares++; $display("FAIL redir_target got valid=%b if_pc=%h instr=%h want 1/100/10000040", if_valid, if_pc, if_instruction);
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        vectors++;
        if (if_valid !== 1'b0) begin miscompares++; $display("FAIL redir_stall_cycle got valid=%b want 0", if_valid); end
        tick();
        redirect = 1'b0; stall = 1'b0;
        #1;
        vectors++;
        if (if_valid !== 1'b0 || pc_out !== 32'h40) begin
            miscompares++; $display("FAIL redir_stall_bubble got valid=%b pc_out=%h want 0/40", if_valid, pc_out);
        end
        tick();
        vectors++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instruction !== 32'h1000_0010) begin
            miscompares++; $display("FAIL redir_stall_target got valid=%b if_pc=%h instr=%h want 1/40/10000010", if_valid, if_pc, if_instruction);
        end
    endtask

    task automatic test_fault();
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        tick();
        vectors++;
        if (if_valid !== 1'b1 || if_fault !== 1'b1 || if_pc !== 32'h102 || if_instruction !== NOP || pc_out !== 32'h106) begin
            miscompares++;
            $display("FAIL fault_misaligned got valid=%b fault=%b if_pc=%h instr=%h pc_out=%h want 1/1/102/13/106",
                     if_valid, if_fault, if_pc, if_instruction, pc_out);
        end
        redirect = 1'b1; redirect_pc = 32'hFFFC;
        tick();
        redirect = 1'b0;
        tick();
        vectors++;
        if (if_valid !== 1'b1 || if_fault !== 1'b0 || if_pc !== 32'hFFFC || if_instruction !== 32'h1000_3FFF) begin
            miscompares++;
            $display("FAIL fault_last_word got valid=%b fault=%b if_pc=%h instr=%h want 1/0/fffc/10003fff",
                     if_valid, if_fault, if_pc, if_instruction);
        end
        tick();
        vectors++;
        if (if_valid !== 1'b1 || if_fault !== 1'b1 || if_pc !== 32'h1_0000 || if_instruction !== NOP) begin
            miscompares++;
            $display("FAIL fault_range got valid=%b fault=%b if_pc=%h instr=%h want 1/1/10000/13",
                     if_valid, if_fault, if_pc, if_instruction);
        end
        redirect = 1'b1; redirect_pc = 32'h20;
        #1;
        vectors++;
        if (if_fault !== 1'b0 || if_valid !== 1'b0) begin
            miscompares++; $display("FAIL fault_vs_redirect got fault=%b valid=%b want 0/0", if_fault, if_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        tick();
        redirect = 1'b0;
        tick();
        vectors++;
        if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_instruction !== 32'h1000_0008) begin
            miscompares++; $display("FAIL pre_reset got valid=%b if_pc=%h instr=%h want 1/20/10000008", if_valid, if_pc, if_instruction);
        end
        stall = 1'b1;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pc_out !== 32'h0 || if_valid !== 1'b0 || if_fault !== 1'b0 || if_instruction !== NOP) begin
            miscompares++;
            $display("FAIL async_reset got pc_out=%h valid=%b fault=%b instr=%h want 0/0/0/13",
                     pc_out, if_valid, if_fault, if_instruction);
        end
        stall = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (if_valid !== 1'b0 || pc_out !== 32'h0) begin
            miscompares++; $display("FAIL restart_release got valid=%b pc_out=%h want 0/0", if_valid, pc_out);
        end
        tick();
        vectors++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instruction !== 32'h1000_0000 || pc_out !== 32'h4) begin
            miscompares++;
            $display("FAIL restart_first got valid=%b if_pc=%h instr=%h pc_out=%h want 1/0/10000000/4",
                     if_valid, if_pc, if_instruction, pc_out);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_fault();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning PC/address width.
REQ-002 SHALL have parameter RAM_SIZE_WIDTH, default 16, meaning log2 of the instruction memory size in bytes.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-005 SHALL have port stall  in  1  downstream not accepting; hold the current instruction.
REQ-006 SHALL have port redirect  in  1  branch/jump/trap taken; discard in-flight fetches.
REQ-007 SHALL have port redirect_pc  in  ADDR_WIDTH  new fetch target, sampled when redirect=1.
REQ-008 SHALL have port pc_out  out  ADDR_WIDTH  address to the instruction memory (the fetch_pc register).
REQ-009 SHALL have port ram_flush  out  1  flush request to the instruction memory; equals redirect combinationally.
REQ-010 SHALL have port ram_instruction  in  32  instruction memory read data, valid 1 cycle after pc_out.
REQ-011 SHALL have port if_valid  out  1  if_instruction/if_pc are valid this cycle.
REQ-012 SHALL have port if_pc  out  ADDR_WIDTH  PC of the presented instruction.
REQ-013 SHALL have port if_instruction  out  32  presented instruction.
REQ-014 SHALL have port if_fault  out  1  presented PC is misaligned (pc[1:0]!=0) or out of range (pc > 2**RAM_SIZE_WIDTH-4).

Function
REQ-015 State SHALL be: fetch_pc; resp_valid, resp_pc, resp_fault (the request issued last cycle); hold_active, hold_instr (stall buffer).
REQ-016 Advance cycle (stall=0, redirect=0): fetch_pc<=fetch_pc+4 (modulo 2**ADDR_WIDTH); resp_pc<=fetch_pc; resp_valid<=1; resp_fault<=fault(fetch_pc); hold_active<=0.
REQ-017 Redirect cycle (redirect=1, stall ignored): fetch_pc<=redirect_pc; resp_valid<=0; hold_active<=0; if_valid=0 in that same cycle.
REQ-018 Stall cycle (stall=1, redirect=0): fetch_pc, resp_* SHALL hold; on the first stall cycle (hold_active=0), hold_instr<=ram_instruction and hold_active<=1.
REQ-019 if_valid SHALL equal resp_valid & !redirect; if_pc SHALL equal resp_pc; if_fault SHALL equal resp_valid & resp_fault & !redirect.
REQ-020 if_instruction SHALL be NOP_INSTR when if_valid=0 or if_fault=1, hold_instr when hold_active=1, else ram_instruction.
REQ-021 Latency: an instruction at address A SHALL appear on if_instruction exactly 1 cycle after pc_out=A with no stall.
REQ-022 A faulting fetch_pc SHALL still be presented on pc_out; the fault SHALL be reported only with its response, never block redirect.
REQ-023 Sequential wrap past 2**RAM_SIZE_WIDTH-4 SHALL continue counting and report if_fault on the out-of-range responses.
REQ-024 Stall deassert: the cycle stall falls SHALL still present hold_instr; the next response SHALL be ram_instruction for fetch_pc.

Reset
REQ-025 While rst_n=0: fetch_pc=RESET_PC, resp_valid=0, resp_pc=0, resp_fault=0, hold_active=0, hold_instr=0; hence if_valid=0, if_fault=0, if_instruction=NOP_INSTR, pc_out=RESET_PC.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state immediately (asynchronously); first if_valid=1 SHALL occur 1 cycle after the first rising edge with rst_n=1.

Structure
REQ-027 NOP_INSTR (32'h0000_0013) and the instruction-length constant (4) SHALL live in the shared package riscv_pkg.
REQ-028 The block SHALL be a single module with no sub-module; the instruction memory is instantiated by the parent.

Verification
REQ-029 Reset release, no stall, memory holding word k at address 4k -> pc_out 0,4,8,...; if_pc 0,4,8,... with if_instruction = word 0,1,2,... one cycle behind.
REQ-030 Stall held 3 cycles while if_pc=0x8 -> if_pc=0x8 and if_instruction=word 2 for all 3 cycles plus release cycle, then 0xC/word 3 with no gap or duplicate.
REQ-031 redirect=1, redirect_pc=0x100 while if_pc=0x10 -> if_valid=0 that cycle and the next; ram_flush=1 that cycle; following cycle if_pc=0x100.
REQ-032 redirect and stall asserted together, redirect_pc=0x40 -> redirect wins; hold_active cleared; if_pc=0x40 two cycles later.
REQ-033 redirect_pc=0x102 -> response at 0x102 has if_valid=1, if_fault=1, if_instruction=0x0000_0013; redirect_pc=0xFFFC then advance -> 0xFFFC no fault, 0x10000 if_fault=1.
REQ-034 rst_n pulled low during a 2-cycle stall at if_pc=0x20 -> outputs reach reset values without a clock edge; after release fetch restarts at RESET_PC.
